men_wb: RTL and testbench
=========================

Name: men_wb

Overview:
- MEM/WB pipeline register and write-back stage of the 16-bit datapath.
- Sits directly downstream of the execute/memory stage and captures the ALU result (Saida_ULA) and data-memory read (Saida_MemoriaDados) along with control.
- Selects the write-back value and drives the register-bank write port.
- Also provides a forwarding tap, a retired-instruction counter and halt tracking.

Parameters:
- DATA_W, 16, datapath width.
- REG_ADDR_W, 3, register index width (8 registers).
- CNT_W, 16, retired-instruction counter width.
- ZERO_REG, 1, when 1, writes to register 0 are suppressed.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold current stage contents.
- flush  in  1  load a bubble instead of the incoming instruction.
- ex_valido  in  1  incoming slot holds a real instruction.
- ex_Hab_Escrita_BR  in  1  instruction writes the register bank.
- ex_controleMUX_WB  in  1  write-back source: 0 = ALU, 1 = data memory.
- ex_reg_destino  in  REG_ADDR_W  destination register.
- ex_halt  in  1  instruction is HALT.
- Saida_ULA  in  DATA_W  ALU result from the EX/MEM stage.
- Saida_MemoriaDados  in  DATA_W  data-memory read from the EX/MEM stage.
- wb_Hab_Escrita  out  1  register-bank write enable.
- wb_endereco  out  REG_ADDR_W  register-bank write address.
- wb_dado  out  DATA_W  register-bank write data.
- fwd_valido  out  1  forwarding tap valid.
- fwd_reg  out  REG_ADDR_W  forwarding tap register.
- fwd_dado  out  DATA_W  forwarding tap data.
- halted  out  1  a HALT has retired.
- contador_instrucoes  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async, immediate):
  - All stage registers clear; valid = 0, novo = 0.
  - wb_Hab_Escrita = 0, wb_endereco = 0, wb_dado = 0.
  - fwd_valido = 0, fwd_reg = 0, fwd_dado = 0.
  - contador_instrucoes = 0, halted = 0.
  - State = EXECUTANDO.
- Edge priority: reset > flush > stall > load.
  - Load: capture all ex_* inputs plus both data inputs; set novo = 1.
  - Flush: valid = 0, novo = 0. Flush overrides a simultaneous stall.
  - Stall: register contents held; novo forced to 0.
- Write-back mux is combinational from the stage register: dado = controleMUX_WB ? mem : ula.
  - Selection is full width, with no extension or truncation.
- Latency: an instruction presented at edge N drives wb_* during cycle N to N+1, i.e. one cycle.
- Retire condition = valid & novo & (state != PARADO).
- Write enable: wb_Hab_Escrita = retire & Hab_Escrita_BR & !halt & !(ZERO_REG & reg_destino == 0).
  - Each instruction therefore writes exactly once, even if stalled for several cycles.
- wb_endereco and wb_dado always show the stage register and mux value, regardless of write enable.
- Forwarding tap:
  - fwd_valido = valid & Hab_Escrita_BR & !halt & !(ZERO_REG & dest == 0).
  - fwd_valido stays asserted through stalls, because the data is stable.
  - fwd_reg = destination register; fwd_dado = write-back mux value.
- Counter: +1 on each cycle with retire = 1, HALT included.
  - Saturates at 2^CNT_W - 1 and does not wrap.
- State machine:
  - EXECUTANDO -> PARADO on a retire edge where halt = 1.
  - PARADO is terminal until reset.
  - In PARADO: halted = 1, no writes, no counting, fwd_valido = 0. Inputs are still captured but have no effect.
- Reset mid-stall or mid-write: the in-flight write is lost and no partial state persists.

Test Plan:
- Reset, then load ULA=0x1234, MEM=0xBEEF, mux=0, dest=3, we=1 -> next cycle wb_Hab_Escrita=1, wb_endereco=3, wb_dado=0x1234, contador=1.
- Same with mux=1 -> wb_dado=0xBEEF.
- Load a write to r5 with stall held 3 cycles:
  - wb_Hab_Escrita=1 for exactly 1 cycle; fwd_valido=1 for 4 cycles; contador +1 only.
- flush and stall together with a valid write to r2 -> no write, fwd_valido=0, contador unchanged.
- Write to dest=0 with ZERO_REG=1 -> wb_Hab_Escrita=0, fwd_valido=0, contador +1.
- HALT retires, then a write to r1 follows:
  - halted=1 from the HALT's write-back cycle onward.
  - The r1 write is suppressed and contador stops.
  - Asserting reset asynchronously clears halted and contador without waiting for a clock edge.
- Preload contador to 0xFFFF by retiring 65535 instructions (or via a forced value in the bench), retire one more -> stays 0xFFFF.

Source files
------------

// File: rtl/men_wb.sv
// MEM/WB pipeline register and write-back stage: captures EX/MEM results, selects the
// write-back value, drives the register-bank write port, a forwarding tap, a retire counter and halt tracking.
module men_wb #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valido,
    input  logic                  ex_Hab_Escrita_BR,
    input  logic                  ex_controleMUX_WB,
    input  logic [REG_ADDR_W-1:0] ex_reg_destino,
    input  logic                  ex_halt,
    input  logic [DATA_W-1:0]     Saida_ULA,
    input  logic [DATA_W-1:0]     Saida_MemoriaDados,
    output logic                  wb_Hab_Escrita,
    output logic [REG_ADDR_W-1:0] wb_endereco,
    output logic [DATA_W-1:0]     wb_dado,
    output logic                  fwd_valido,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0]     fwd_dado,
    output logic                  halted,
    output logic [CNT_W-1:0]      contador_instrucoes
);

    typedef enum logic {
        EXECUTANDO = 1'b0,
        PARADO     = 1'b1
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic                  novo;
        logic                  we;
        logic                  mux_mem;
        logic [REG_ADDR_W-1:0] dest;
        logic                  halt;
        logic [DATA_W-1:0]     ula;
        logic [DATA_W-1:0]     mem;
    } stage_t;

    stage_t           stage_q, stage_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic              retire;
    logic              dest_is_zero;
    logic              writes_reg;
    logic [DATA_W-1:0] wb_value;

    // novo marks the first cycle an instruction sits in the stage, so a
    // stalled instruction retires (and writes) only once.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        stage_d = stage_q;
        if (flush) begin
            stage_d.valid = 1'b0;
            stage_d.novo  = 1'b0;
        end else if (stall) begin
            stage_d.novo = 1'b0;
        end else begin
            stage_d.valid   = ex_valido;
            stage_d.novo    = 1'b1;
            stage_d.we      = ex_Hab_Escrita_BR;
            stage_d.mux_mem = ex_controleMUX_WB;
            stage_d.dest    = ex_reg_destino;
            stage_d.halt    = ex_halt;
            stage_d.ula     = Saida_ULA;
            stage_d.mem     = Saida_MemoriaDados;
        end
    end

    assign wb_value     = stage_q.mux_mem ? stage_q.mem : stage_q.ula;
    assign dest_is_zero = (ZERO_REG != 0) && (stage_q.dest == '0);
    assign writes_reg   = stage_q.valid && stage_q.we && !stage_q.halt && !dest_is_zero;
    assign retire       = stage_q.valid && stage_q.novo && (state_q != PARADO);

    always_comb begin
        state_d = state_q;
        if (state_q == EXECUTANDO && retire && stage_q.halt) begin
            state_d = PARADO;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (retire && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
            state_q <= EXECUTANDO;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            stage_q <= stage_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign wb_Hab_Escrita      = retire && writes_reg;
    assign wb_endereco         = stage_q.dest;
    assign wb_dado             = wb_value;

    // Forwarding stays valid across stalls because the stage contents are frozen.
    assign fwd_valido          = writes_reg && (state_q == EXECUTANDO);
    assign fwd_reg             = stage_q.dest;
    assign fwd_dado            = wb_value;

    // The HALT reports itself during its own write-back cycle, before the state flips.
    assign halted              = (state_q == PARADO) || (retire && stage_q.halt);
    assign contador_instrucoes = cnt_q;

endmodule

// File: tb/tb_men_wb.sv
// Self-checking bench for men_wb: a table of back-to-back write-backs plus
// hand-written stall, flush, zero-register, halt, async-reset and saturation sequences.
module tb_men_wb;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall, flush;
    logic        ex_valido, ex_Hab_Escrita_BR, ex_controleMUX_WB, ex_halt;
    logic [2:0]  ex_reg_destino;
    logic [15:0] Saida_ULA, Saida_MemoriaDados;
    logic        wb_Hab_Escrita, fwd_valido, halted;
    logic [2:0]  wb_endereco, fwd_reg;
    logic [15:0] wb_dado, fwd_dado, contador_instrucoes;

    int checks   = 0;
    int failures = 0;

    men_wb dut (
        .clock               (clock),
        .reset               (reset),
        .stall               (stall),
        .flush               (flush),
        .ex_valido           (ex_valido),
        .ex_Hab_Escrita_BR   (ex_Hab_Escrita_BR),
        .ex_controleMUX_WB   (ex_controleMUX_WB),
        .ex_reg_destino      (ex_reg_destino),
        .ex_halt             (ex_halt),
        .Saida_ULA           (Saida_ULA),
        .Saida_MemoriaDados  (Saida_MemoriaDados),
        .wb_Hab_Escrita      (wb_Hab_Escrita),
        .wb_endereco         (wb_endereco),
        .wb_dado             (wb_dado),
        .fwd_valido          (fwd_valido),
        .fwd_reg             (fwd_reg),
        .fwd_dado            (fwd_dado),
        .halted              (halted),
        .contador_instrucoes (contador_instrucoes)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v, we, mux, halt;
        logic [2:0]  dest;
        logic [15:0] ula, mem;
        logic        exp_we, exp_fwd, exp_ret;
        logic [15:0] exp_dado;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic mux, input logic [2:0] dest,
                         input logic halt, input logic [15:0] ula, input logic [15:0] mem);
        ex_valido          = v;
        ex_Hab_Escrita_BR  = we;
        ex_controleMUX_WB  = mux;
        ex_reg_destino     = dest;
        ex_halt            = halt;
        Saida_ULA          = ula;
        Saida_MemoriaDados = mem;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    endtask

    logic [15:0] exp_cnt;
    int          we_cycles, fwd_cycles;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h1234, 16'hBEEF, 1'b1, 1'b1, 1'b1, 16'h1234};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 16'h1234, 16'hBEEF, 1'b1, 1'b1, 1'b1, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0055, 16'h9999, 1'b0, 1'b0, 1'b1, 16'h0055};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 16'h7777, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h7777};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 16'h2222, 16'h8001, 1'b0, 1'b0, 1'b1, 16'h8001};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'hFFFF};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 16'hA5A5, 16'h5A5A, 1'b1, 1'b1, 1'b1, 16'hA5A5};

        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 16'hAAAA, 16'h5555);
        #2;
        check("reset_we",   wb_Hab_Escrita, 0);
        check("reset_addr", wb_endereco, 0);
        check("reset_dado", wb_dado, 0);
        check("reset_fwd",  {fwd_valido, fwd_reg, fwd_dado}, 0);
        check("reset_halt", halted, 0);
        check("reset_cnt",  contador_instrucoes, 0);
        tick();
        check("reset_hold_we", wb_Hab_Escrita, 0);
        reset = 1'b0;
        bubble();
        tick();

        // Table: back-to-back loads, one retirement per cycle.
        exp_cnt = 16'd0;
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v, vecs[i].we, vecs[i].mux, vecs[i].dest, vecs[i].halt, vecs[i].ula, vecs[i].mem);
            tick();
            check($sformatf("vec%0d_we", i),   wb_Hab_Escrita, vecs[i].exp_we);
            check($sformatf("vec%0d_addr", i), wb_endereco, vecs[i].dest);
            check($sformatf("vec%0d_dado", i), wb_dado, vecs[i].exp_dado);
            check($sformatf("vec%0d_fwd", i),  fwd_valido, vecs[i].exp_fwd);
            check($sformatf("vec%0d_fwd_dado", i), fwd_dado, vecs[i].exp_dado);
            check($sformatf("vec%0d_cnt", i),  contador_instrucoes, exp_cnt);
            if (vecs[i].exp_ret) exp_cnt = exp_cnt + 16'd1;
        end
        bubble();
        tick();
        check("table_cnt_final", contador_instrucoes, exp_cnt);

        // Write to r5 held by a 3-cycle stall: one write, four forwarding cycles.
        we_cycles  = 0;
        fwd_cycles = 0;
        drive(1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 16'h0505, 16'hDEAD);
        tick();
        if (wb_Hab_Escrita) we_cycles++;
        if (fwd_valido) fwd_cycles++;
        stall = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 16'hDEAD, 16'hDEAD);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (wb_Hab_Escrita) we_cycles++;
            if (fwd_valido) fwd_cycles++;
            check($sformatf("stall%0d_addr", c), wb_endereco, 5);
            check($sformatf("stall%0d_dado", c), wb_dado, 16'h0505);
        end
        stall = 1'b0;
        bubble();
        tick();
        check("stall_we_cycles",  we_cycles, 1);
        check("stall_fwd_cycles", fwd_cycles, 4);
        exp_cnt = exp_cnt + 16'd1;
        check("stall_cnt", contador_instrucoes, exp_cnt);

        // Flush wins over a simultaneous stall.
        flush = 1'b1;
        stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 16'h2222, 16'h0000);
        tick();
        check("flush_we",  wb_Hab_Escrita, 0);
        check("flush_fwd", fwd_valido, 0);
        flush = 1'b0;
        stall = 1'b0;
        bubble();
        tick();
        check("flush_cnt", contador_instrucoes, exp_cnt);

        // HALT retires, then a write to r1 is ignored.
        drive(1'b1, 1'b1, 1'b0, 3'd4, 1'b1, 16'h4444, 16'h0000);
        tick();
        check("halt_wb_halted", halted, 1);
        check("halt_wb_we",     wb_Hab_Escrita, 0);
        check("halt_wb_fwd",    fwd_valido, 0);
        exp_cnt = exp_cnt + 16'd1;
        drive(1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 16'h1111, 16'h0000);
        tick();
        check("post_halt_halted", halted, 1);
        check("post_halt_we",     wb_Hab_Escrita, 0);
        check("post_halt_fwd",    fwd_valido, 0);
        check("post_halt_cnt",    contador_instrucoes, exp_cnt);
        drive(1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 16'h2121, 16'h0000);
        tick();
        check("halt_cnt_frozen", contador_instrucoes, exp_cnt);

        // Asynchronous reset mid-cycle, sampled before the next edge.
        #2;
        reset = 1'b1;
        #1;
        check("async_halted", halted, 0);
        check("async_cnt",    contador_instrucoes, 0);
        check("async_we",     wb_Hab_Escrita, 0);
        check("async_fwd",    fwd_valido, 0);
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 16'h1111, 16'h0000);
        tick();
        check("after_reset_we",   wb_Hab_Escrita, 1);
        check("after_reset_dado", wb_dado, 16'h1111);

        // Counter saturation: preload just below the top, retire two more.
        bubble();
        tick();
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        drive(1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 16'h0001, 16'h0000);
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 16'h0002, 16'h0000);
        tick();
        check("sat_reach_max", contador_instrucoes, 16'hFFFF);
        check("sat_still_writes", wb_Hab_Escrita, 1);
        bubble();
        tick();
        check("sat_no_wrap", contador_instrucoes, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
